mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO result registers, parametrised in operand width and operation latency. It sits beside the single-cycle ALU in the execute stage. It accepts one operation per start pulse and holds `busy` high for the modelled latency so the pipeline can stall dependent HI/LO reads. It also supports direct HI/LO writes.

## Interface
- `WIDTH`, 32, operand and HI/LO register width.
- `MUL_CYCLES`, 5, busy duration of multiply ops; must be ≥1.
- `DIV_CYCLES`, 10, busy duration of divide ops; must be ≥1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: request; sampled on the rising edge.
- `op` input 3: operation code, sampled with `start`.
- `A` input WIDTH: operand rs (dividend / multiplicand / MTHI-MTLO source).
- `B` input WIDTH: operand rt (divisor / multiplier).
- `busy` output 1: operation in flight.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- Op codes:
  - MULTU=0: unsigned product.
  - MULT=1: signed product.
  - DIVU=2: unsigned divide.
  - DIV=3: signed divide.
  - MTHI=4, MTLO=5: direct writes.
  - 6 and 7: reserved no-ops.
- States: IDLE, RUN.
- **IDLE, `start`=1, op is a multiply or divide:**
  - Latch A, B and op.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- **IDLE, `start`=1, MTHI/MTLO:**
  - Write A into hi or lo at that edge.
  - Stay IDLE; `busy` stays 0.
- **RUN:**
  - Counter decrements each edge.
  - On the edge where it reaches 0: write hi/lo, go to IDLE.
- `start` while RUN:
  - Ignored entirely, including MTHI/MTLO.
  - Operands are not re-latched.
  - The pipeline must stall instead.
- Multiply results:
  - 2·WIDTH-bit product; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - MULT treats A and B as two's complement; MULTU treats them as unsigned.
- Divide results:
  - lo = quotient, hi = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide boundary cases:
  - Divide by zero (B=0): the operation still runs the full DIV_CYCLES. At completion hi and lo keep their previous values.
  - DIV overflow (A = most-negative value, B = −1): lo = most-negative value, hi = 0.
- Results are computed from the latched operands only. A/B changes during RUN have no effect.
- Reserved op with `start`: no state change.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `reset` asserted mid-operation aborts immediately (asynchronously). No partial result is written.
- Start of an operation (accepting edge t0):
  - `busy` is combinationally derived from state: 1 after t0 while in RUN.
  - `busy` stays 1 for exactly MUL_CYCLES / DIV_CYCLES cycles.
  - hi/lo update at edge t0+N, where N is the op latency.
  - `busy` falls at that same edge.
- Back-to-back operation:
  - A new `start` is accepted at the edge t0+N only if `busy` was 0 before that edge. It is therefore not accepted at t0+N.
  - The earliest next acceptance is edge t0+N+1.
- MTHI/MTLO update hi/lo at the sampling edge: latency 1 edge, visible the following cycle.
- hi/lo are registered outputs. There is no combinational path from A, B or op to the outputs.

## Structure
- Package `mdu_pkg`:
  - op-code localparams (`MDU_MULTU` … `MDU_MTLO`);
  - state encoding (`MDU_IDLE`, `MDU_RUN`).
- Sub-module `mdu_calc` (purely combinational):
  - inputs: latched A, B and op;
  - outputs: `res_hi`, `res_lo` and `div_zero`;
  - contains all signed/unsigned arithmetic and boundary handling.
- Top `mult_div_unit` contains:
  - the FSM and counter;
  - the operand latches;
  - the HI/LO registers;
  - the write-enable logic.
- Counter width: $clog2 of the larger of MUL_CYCLES and DIV_CYCLES, plus 1.

## Test plan
- **Reset:** assert `reset` mid-RUN of a DIV → `busy`=0, hi=0, lo=0 immediately. After release, hi/lo stay 0 with no completion write.
- **MULT:** A=0xFFFFFFFE (−2), B=3 → `busy` high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Same operands with MULTU → hi=0x00000002, lo=0xFFFFFFFA.
- **DIV:** A=−7 (0xFFFFFFF9), B=2 → after 10 cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - DIVU 7/2 → lo=3, hi=1.
- **Divide boundaries:**
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV by 0 → `busy` 10 cycles, hi=0x11, lo=0x22 unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- **Start while busy:** issue MULT 3×4, then during RUN issue `start` with MTLO A=0xABCD and a second MULT → both ignored. Final hi=0, lo=12.
  - Next start accepted only one cycle after `busy` falls.
- **Parametrised build:** WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3, MULT 0x8000×0x8000 → `busy` 1 cycle, hi=0x4000, lo=0x0000.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and
// op classification helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MULTU = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_DIVU  = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_mul(input logic [2:0] op);
    return (op == MDU_MULTU) || (op == MDU_MULT);
  endfunction

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, A, B,
    output busy, hi, lo
  );

endinterface

// File: rtl/mdu_calc.sv
// Combinational datapath for the multiply/divide unit. One multiplier and one
// divider are shared between the signed and unsigned variants.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic             a_ext;
  logic             b_ext;
  logic [W2-1:0]    a_wide;
  logic [W2-1:0]    b_wide;
  logic [W2-1:0]    prod;
  logic             is_sdiv;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Shared multiplier: sign- or zero-extend to 2*WIDTH, low 2*WIDTH bits are exact
  always_comb begin
    a_ext  = (op == MDU_MULT) ? a[WIDTH-1] : 1'b0;
    b_ext  = (op == MDU_MULT) ? b[WIDTH-1] : 1'b0;
    a_wide = {{WIDTH{a_ext}}, a};
    b_wide = {{WIDTH{b_ext}}, b};
    prod   = a_wide * b_wide;
  end

  // Shared divider on magnitudes; the divisor is forced to 1 on divide-by-zero
  // so the result is well defined (it is discarded by the top anyway).
  // Most-negative / -1 falls out naturally: |A| = 2^(W-1), negated back.
  always_comb begin
    is_sdiv  = (op == MDU_DIV);
    a_neg    = is_sdiv & a[WIDTH-1];
    b_neg    = is_sdiv & b[WIDTH-1];
    div_zero = (b == '0);
    dvd      = a_neg ? (~a + 1'b1) : a;
    dvs      = b_neg ? (~b + 1'b1) : b;
    if (div_zero) begin
      dvs = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    quo = dvd / dvs;
    rem = dvd % dvs;
  end

  // Result select: quotient sign follows operand signs, remainder follows dividend
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      MDU_MULTU, MDU_MULT: begin
        res_hi = prod[W2-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      MDU_DIVU, MDU_DIV: begin
        res_lo = (a_neg ^ b_neg) ? (~quo + 1'b1) : quo;
        res_hi = a_neg ? (~rem + 1'b1) : rem;
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. Models the op latency
// with a down-counter and holds busy for its duration; MTHI/MTLO write directly.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // Next state: accept in IDLE only, count down in RUN, commit on the last edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (bus.start) begin
          if (mdu_is_mul(bus.op) || mdu_is_div(bus.op)) begin
            a_d     = bus.A;
            b_d     = bus.B;
            op_d    = bus.op;
            cnt_d   = mdu_is_mul(bus.op) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            state_d = MDU_RUN;
          end else if (bus.op == MDU_MTHI) begin
            hi_d = bus.A;
          end else if (bus.op == MDU_MTLO) begin
            lo_d = bus.A;
          end
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_IDLE;
          // Divide by zero runs full length but leaves HI/LO untouched
          if (!(mdu_is_div(op_q) && div_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase
  end

  // State, operand latches and HI/LO registers; reset aborts any operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == MDU_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: 32-bit default build plus a 16-bit
// build with short latencies, checked against a scoreboard fed by a wide
// integer reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb_q[$];
  logic [31:0] mhi32 = '0;
  logic [31:0] mlo32 = '0;
  logic [31:0] mhi16 = '0;
  logic [31:0] mlo16 = '0;

  mult_div_unit_if #(.WIDTH(32)) m32 ();
  mult_div_unit_if #(.WIDTH(16)) m16 ();

  mult_div_unit #(
    .WIDTH      (32),
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m32)
  );

  mult_div_unit #(
    .WIDTH      (16),
    .MUL_CYCLES (1),
    .DIV_CYCLES (3)
  ) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (m16)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model on 64-bit integers; returns {hi, lo} zero-extended to 32 bits
  function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w,
                                            input logic [63:0] prev);
    logic [63:0] mask, ua, ub, pu, hi, lo;
    longint sa, sb, ps, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = a[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
    sb = b[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
    hi = {32'd0, prev[63:32]};
    lo = {32'd0, prev[31:0]};
    case (op)
      3'd0: begin pu = ua * ub; hi = (pu >> w) & mask; lo = pu & mask; end
      3'd1: begin ps = sa * sb; pu = ps; hi = (pu >> w) & mask; lo = pu & mask; end
      3'd2: if (ub != 0) begin hi = (ua % ub) & mask; lo = (ua / ub) & mask; end
      3'd3: if (sb != 0) begin
        q = sa / sb; r = sa % sb;
        pu = r; hi = pu & mask;
        pu = q; lo = pu & mask;
      end
      3'd4: hi = ua;
      3'd5: lo = ua;
      default: ;
    endcase
    return {hi[31:0], lo[31:0]};
  endfunction

  function automatic int lat(input bit s16, input logic [2:0] op);
    if (op == MDU_MULT || op == MDU_MULTU) return s16 ? 1 : 5;
    if (op == MDU_DIV || op == MDU_DIVU) return s16 ? 3 : 10;
    return 0;
  endfunction

  function automatic logic cur_busy(input bit s16);
    return s16 ? m16.busy : m32.busy;
  endfunction

  function automatic logic [31:0] cur_hi(input bit s16);
    return s16 ? {16'd0, m16.hi} : m32.hi;
  endfunction

  function automatic logic [31:0] cur_lo(input bit s16);
    return s16 ? {16'd0, m16.lo} : m32.lo;
  endfunction

  // Push expectation, drive one start pulse, then scramble operands after acceptance
  task automatic issue(input bit s16, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] exp;
    exp = model_res(op, a, b, s16 ? 16 : 32, s16 ? {mhi16, mlo16} : {mhi32, mlo32});
    if (s16) {mhi16, mlo16} = exp;
    else {mhi32, mlo32} = exp;
    sb_q.push_back(exp);
    @(negedge clk);
    if (s16) begin
      m16.start = 1'b1; m16.op = op; m16.A = a[15:0]; m16.B = b[15:0];
    end else begin
      m32.start = 1'b1; m32.op = op; m32.A = a; m32.B = b;
    end
    @(posedge clk);
    #1;
    m16.start = 1'b0;
    m32.start = 1'b0;
    m16.A = 16'($urandom); m16.B = 16'($urandom);
    m32.A = $urandom;      m32.B = $urandom;
  endtask

  task automatic wait_idle(input bit s16, output int cycles);
    cycles = 0;
    while (cur_busy(s16) && cycles < 64) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [63:0] exp;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (m32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", m32.busy); end
    if (m32.hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", m32.hi); end
    if (m32.lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", m32.lo); end
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, MDU_MTHI, 32'h11, 32'h0);
    issue(1'b0, MDU_MTLO, 32'h22, 32'h0);
    wait_idle(1'b0, cyc);
    exp = sb_q.pop_front();
    exp = sb_q.pop_front();
    checks += 2;
    if (m32.hi !== exp[63:32]) begin errors++; $display("FAIL preload_hi: got %h expected %h", m32.hi, exp[63:32]); end
    if (m32.lo !== exp[31:0]) begin errors++; $display("FAIL preload_lo: got %h expected %h", m32.lo, exp[31:0]); end
    issue(1'b0, MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks += 3;
    if (m32.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", m32.busy); end
    if (m32.hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h expected 0", m32.hi); end
    if (m32.lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h expected 0", m32.lo); end
    sb_q.delete();
    mhi32 = '0; mlo32 = '0; mhi16 = '0; mlo16 = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks += 3;
    if (m32.busy !== 1'b0) begin errors++; $display("FAIL post_abort_busy: got %b expected 0", m32.busy); end
    if (m32.hi !== 32'd0) begin errors++; $display("FAIL post_abort_hi: got %h expected 0", m32.hi); end
    if (m32.lo !== 32'd0) begin errors++; $display("FAIL post_abort_lo: got %h expected 0", m32.lo); end
  endtask

  task automatic test_ops(input string name, input bit s16, input logic [2:0] ops[],
                          input logic [31:0] as[], input logic [31:0] bs[]);
    int cyc;
    logic [63:0] exp;
    for (int i = 0; i < ops.size(); i++) begin
      issue(s16, ops[i], as[i], bs[i]);
      wait_idle(s16, cyc);
      exp = sb_q.pop_front();
      checks += 3;
      if (cyc !== lat(s16, ops[i])) begin
        errors++;
        $display("FAIL %s[%0d]_busy_cycles: got %0d expected %0d", name, i, cyc, lat(s16, ops[i]));
      end
      if (cur_hi(s16) !== exp[63:32]) begin
        errors++;
        $display("FAIL %s[%0d]_hi: got %h expected %h", name, i, cur_hi(s16), exp[63:32]);
      end
      if (cur_lo(s16) !== exp[31:0]) begin
        errors++;
        $display("FAIL %s[%0d]_lo: got %h expected %h", name, i, cur_lo(s16), exp[31:0]);
      end
    end
  endtask

  task automatic test_mult();
    logic [2:0]  ops[] = '{MDU_MULT, MDU_MULTU, MDU_MULT, MDU_MULTU};
    logic [31:0] as[]  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs[]  = '{32'd3, 32'd3, 32'h80000000, 32'hFFFFFFFF};
    test_ops("mult", 1'b0, ops, as, bs);
  endtask

  task automatic test_div();
    logic [2:0]  ops[] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIV};
    logic [31:0] as[]  = '{32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFF9};
    logic [31:0] bs[]  = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
    test_ops("div", 1'b0, ops, as, bs);
  endtask

  task automatic test_div_boundary();
    logic [2:0]  ops[] = '{MDU_MTHI, MDU_MTLO, MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIVU};
    logic [31:0] as[]  = '{32'h11, 32'h22, 32'h1234, 32'h5678, 32'h80000000, 32'h80000000};
    logic [31:0] bs[]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    test_ops("divbound", 1'b0, ops, as, bs);
  endtask

  task automatic test_reserved();
    logic [2:0]  ops[] = '{3'd6, 3'd7};
    logic [31:0] as[]  = '{32'hCAFE, 32'hBEEF};
    logic [31:0] bs[]  = '{32'h1, 32'h2};
    test_ops("reserved", 1'b0, ops, as, bs);
  endtask

  task automatic test_random();
    logic [2:0]  ops[] = new[12];
    logic [31:0] as[]  = new[12];
    logic [31:0] bs[]  = new[12];
    for (int i = 0; i < 12; i++) begin
      ops[i] = 3'($urandom_range(0, 3));
      as[i]  = $urandom;
      case (i % 4)
        0: bs[i] = $urandom;
        1: bs[i] = $urandom_range(1, 9);
        2: bs[i] = 32'hFFFFFFFF;
        default: bs[i] = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      endcase
    end
    test_ops("random", 1'b0, ops, as, bs);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] exp;
    issue(1'b0, MDU_MULT, 32'd3, 32'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      m32.start = 1'b1;
      if (k == 1) begin m32.op = MDU_MTLO; m32.A = 32'hABCD; end
      else if (k == 2) begin m32.op = MDU_MULT; m32.A = 32'd100; m32.B = 32'd100; end
      else begin m32.op = MDU_MTHI; m32.A = 32'h55; end
      @(posedge clk);
      #1;
      if (k < 5) begin
        checks++;
        if (m32.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d]: got %b expected 1", k, m32.busy); end
      end
    end
    exp = sb_q.pop_front();
    checks += 3;
    if (m32.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall: got %b expected 0", m32.busy); end
    if (m32.hi !== exp[63:32]) begin errors++; $display("FAIL b2b_hi: got %h expected %h", m32.hi, exp[63:32]); end
    if (m32.lo !== exp[31:0]) begin errors++; $display("FAIL b2b_lo: got %h expected %h", m32.lo, exp[31:0]); end
    // start held high across the falling edge of busy: accepted one edge later
    mhi32 = 32'h55;
    sb_q.push_back({mhi32, mlo32});
    @(posedge clk);
    #1;
    m32.start = 1'b0;
    wait_idle(1'b0, cyc);
    exp = sb_q.pop_front();
    checks += 2;
    if (m32.hi !== exp[63:32]) begin errors++; $display("FAIL b2b_next_hi: got %h expected %h", m32.hi, exp[63:32]); end
    if (m32.lo !== exp[31:0]) begin errors++; $display("FAIL b2b_next_lo: got %h expected %h", m32.lo, exp[31:0]); end
  endtask

  task automatic test_param16();
    logic [2:0]  ops[] = '{MDU_MULT, MDU_DIV, MDU_MULTU, MDU_DIVU};
    logic [31:0] as[]  = '{32'h8000, 32'hFFF9, 32'hFFFF, 32'hFFFF};
    logic [31:0] bs[]  = '{32'h8000, 32'h2, 32'hFFFF, 32'h10};
    test_ops("param16", 1'b1, ops, as, bs);
  endtask

  initial begin
    m32.start = 1'b0; m32.op = '0; m32.A = '0; m32.B = '0;
    m16.start = 1'b0; m16.op = '0; m16.A = '0; m16.B = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_boundary();
    test_reserved();
    test_back_to_back();
    test_random();
    test_param16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
